// File: rtl/wb_burst_reader.sv
// Wishbone pipelined read master: fetches a block of consecutive 16-bit words
// and delivers them in address order on a ready/valid stream.
module wb_burst_reader #(
  parameter int unsigned AW    = 16,
  parameter int unsigned LW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_adr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  output logic [15:0]   out_dat,
  input  logic          out_ready,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  input  logic [15:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_stall_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e          state_q;
  logic            busy_q, done_q, cyc_q, stb_q;
  logic [AW-1:0]   adr_q;
  logic [LW-1:0]   rem_q;
  logic [CW-1:0]   outst_q;
  logic [15:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   mem_cnt_q;
  logic            out_valid_q;
  logic [15:0]     out_dat_q;

  logic            accept, push, pop, out_free;
  logic            mem_push, mem_pop, direct;
  logic [LW-1:0]   rem_d;
  logic [CW-1:0]   outst_d, fifo_cnt, fifo_cnt_d, mem_cnt_d;
  logic            credit_ok, drain_done;

  // Bus/FIFO bookkeeping for the coming edge.
  always_comb begin
    accept     = stb_q & ~wb_stall_i;
    push       = cyc_q & wb_ack_i;
    pop        = out_valid_q & out_ready;
    out_free   = ~out_valid_q | pop;
    mem_pop    = out_free & (mem_cnt_q != '0);
    direct     = out_free & (mem_cnt_q == '0) & push;
    mem_push   = push & ~direct;
    mem_cnt_d  = mem_cnt_q + CW'(mem_push) - CW'(mem_pop);
    rem_d      = rem_q - LW'(accept);
    outst_d    = outst_q + CW'(accept) - CW'(push);
    fifo_cnt   = mem_cnt_q + CW'(out_valid_q);
    fifo_cnt_d = fifo_cnt + CW'(push) - CW'(pop);
    // Outstanding requests plus buffered words must leave room for every ack.
    credit_ok  = (SW'(outst_d) + SW'(fifo_cnt_d)) < SW'(DEPTH);
    // Finished once the bus is quiet and only the final word (if any) is presented.
    drain_done = (state_q == S_DRAIN) & (outst_d == '0) & (fifo_cnt_d <= CW'(1));
  end

  // Transfer control FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      rem_q   <= '0;
      outst_q <= '0;
    end else begin
      done_q  <= 1'b0;
      outst_q <= outst_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              busy_q  <= 1'b1;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              adr_q   <= base_adr;
              rem_q   <= length;
            end
          end
        end
        S_ISSUE: begin
          if (accept) begin
            adr_q <= adr_q + AW'(1);
            rem_q <= rem_d;
          end
          if (accept && (rem_d == '0)) begin
            state_q <= S_DRAIN;
            stb_q   <= 1'b0;
          end else if (!(stb_q && wb_stall_i)) begin
            stb_q <= credit_ok;
          end
        end
        S_DRAIN: begin
          if (outst_d == '0) cyc_q <= 1'b0;
          if (drain_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-data FIFO: ring buffer behind a registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (mem_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (mem_pop) begin
        out_dat_q   <= mem_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        out_valid_q <= 1'b1;
      end else if (direct) begin
        out_dat_q   <= wb_dat_i;
        out_valid_q <= 1'b1;
      end else if (out_free) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) mem_q[wr_ptr_q] <= wb_dat_i;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_dat   = out_dat_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = 1'b0;
  assign wb_adr_o  = adr_q;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: pipelined ROM slave model, scoreboard of expected
// stream words, table of transfers plus hand-written corner sequences.
module tb_wb_burst_reader;

  localparam int unsigned AW    = 16;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] base_adr;
  logic [LW-1:0] length;
  logic          busy, done, out_valid, out_ready;
  logic [15:0]   out_dat;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [15:0]   wb_dat_i;
  logic          wb_ack_i, wb_stall_i;

  always #5 clk = ~clk;

  wb_burst_reader #(.AW(AW), .LW(LW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .length(length),
    .busy(busy), .done(done), .out_valid(out_valid), .out_dat(out_dat),
    .out_ready(out_ready), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  typedef struct {
    logic [15:0] base;
    int          len;
    bit          stall;
    int          rmode;   // 0: always ready, 1: random ready
    int          lat;     // expected start-to-done cycles, 0 = unchecked
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] sb [$];
  int          n_checks = 0, n_fail = 0;
  int          cyc_cnt, reqs, acks, done_cnt, done_cyc;
  bit          cyc_seen, busy_seen;
  logic [AW-1:0] exp_adr;
  bit          pend, stall_mode, ack_en, stray;
  logic [15:0] pend_dat;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Observe what the coming edge will do, then step to the next cycle and drive the slave.
  task automatic cycle();
    logic [15:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_word: got 0x%0h with no word expected", out_dat);
      end else begin
        e = sb.pop_front();
        check("out_dat", 32'(out_dat), 32'(e));
      end
    end
    if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
      check("wb_adr", 32'(wb_adr_o), 32'(exp_adr));
      exp_adr  = exp_adr + 16'd1;
      reqs++;
      pend     = ack_en;
      pend_dat = rom(wb_adr_o);
    end else begin
      pend = 1'b0;
    end
    if (wb_ack_i && wb_cyc_o) acks++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_cnt;
    end
    if (wb_cyc_o) cyc_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (wb_stb_o && !wb_cyc_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL stb_without_cyc: got stb=1 cyc=0 expected cyc=1");
    end
    @(negedge clk);
    cyc_cnt++;
    wb_ack_i   = pend || stray;
    wb_dat_i   = stray ? 16'hDEAD : pend_dat;
    wb_stall_i = stall_mode ? !wb_stall_i : 1'b0;
  endtask

  task automatic prep(input logic [15:0] base, input int len);
    logic [15:0] a;
    exp_adr   = base;
    reqs      = 0;
    acks      = 0;
    done_cnt  = 0;
    cyc_seen  = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = base + 16'(i);
      sb.push_back(rom(a));
    end
  endtask

  task automatic run_xfer(input logic [15:0] base, input int len, input bit stall,
                          input int rmode, input int lat, input int poke);
    int t0, guard;
    stall_mode = stall;
    ack_en     = 1'b1;
    prep(base, len);
    out_ready  = 1'b1;
    start      = 1'b1;
    base_adr   = base;
    length     = LW'(len);
    t0         = cyc_cnt;
    cycle();
    start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      if (guard == poke) begin
        start    = 1'b1;
        base_adr = 16'h9000;
        length   = LW'(5);
      end
      cycle();
      start = 1'b0;
      guard++;
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    if (lat != 0) check("done_latency", 32'(done_cyc - t0), 32'(lat));
    out_ready = 1'b1;
    repeat (4) cycle();
    stall_mode = 1'b0;
    check("requests", 32'(reqs), 32'(len));
    check("acks", 32'(acks), 32'(len));
    check("words_left", 32'(sb.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("cyc_seen", 32'(cyc_seen), 32'(len != 0));
    check("busy_seen", 32'(busy_seen), 32'(len != 0));
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int guard;
    vecs[0] = '{16'h0010,  8, 1'b0, 0, 10};
    vecs[1] = '{16'h0200,  5, 1'b1, 0,  0};
    vecs[2] = '{16'hFFFE,  4, 1'b0, 0,  6};
    vecs[3] = '{16'h1234,  1, 1'b0, 0,  3};
    vecs[4] = '{16'h0040,  0, 1'b0, 0,  1};
    vecs[5] = '{16'h0100, 20, 1'b1, 1,  0};
    vecs[6] = '{16'h0300, 16, 1'b0, 0, 18};

    rst = 1'b1; start = 1'b0; base_adr = '0; length = '0; out_ready = 1'b1;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    pend = 1'b0; pend_dat = '0; stall_mode = 1'b0; ack_en = 1'b1; stray = 1'b0;
    cyc_cnt = 0; exp_adr = '0; done_cyc = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("we_low", 32'(wb_we_o), 32'd0);
    rst = 1'b0;
    cycle();

    for (int v = 0; v < 7; v++)
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].stall, vecs[v].rmode, vecs[v].lat, -1);

    // Start strobe while busy must not disturb a length-3 transfer.
    run_xfer(16'h0700, 3, 1'b0, 0, 5, 1);

    // Consumer stalled: credits cap requests at DEPTH, then the rest flows.
    stall_mode = 1'b0;
    ack_en     = 1'b1;
    prep(16'h0500, 10);
    out_ready = 1'b0;
    start = 1'b1; base_adr = 16'h0500; length = LW'(10);
    cycle();
    start = 1'b0;
    repeat (20) cycle();
    check("credit_reqs", 32'(reqs), 32'(DEPTH));
    check("credit_cyc", 32'(wb_cyc_o), 32'd1);
    check("credit_stb", 32'(wb_stb_o), 32'd0);
    check("credit_valid", 32'(out_valid), 32'd1);
    check("credit_head", 32'(out_dat), 32'(rom(16'h0500)));
    out_ready = 1'b1;
    guard = 0;
    while (done_cnt == 0 && guard < 200) begin
      cycle();
      guard++;
    end
    repeat (4) cycle();
    check("credit_done", 32'(done_cnt), 32'd1);
    check("credit_total_reqs", 32'(reqs), 32'd10);
    check("credit_words_left", 32'(sb.size()), 32'd0);

    // Reset with two requests outstanding, then stray acks, then a clean transfer.
    ack_en = 1'b0;
    prep(16'h0800, 10);
    start = 1'b1; base_adr = 16'h0800; length = LW'(10);
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check("outstanding_before_rst", 32'(reqs), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_cyc", 32'(wb_cyc_o), 32'd0);
    check("abort_stb", 32'(wb_stb_o), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    sb.delete();
    done_cnt = 0;
    ack_en = 1'b1;
    stray  = 1'b1;
    repeat (3) cycle();
    stray = 1'b0;
    cycle();
    check("stray_valid", 32'(out_valid), 32'd0);
    check("stray_no_done", 32'(done_cnt), 32'd0);
    run_xfer(16'h0900, 6, 1'b0, 0, 8, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
- Wishbone classic-pipelined bus master; reads a block of consecutive 16-bit words from any pipelined Wishbone slave (ROM, RAM) and presents them as a ready/valid stream.
- Sits between a loader or copy engine and the slave fabric. It is the initiator counterpart of the pipelined slaves in the codebase, and it honours stall and wait-state responses from those slaves.

Parameters:
- AW, 16, Wishbone word-address width; address wraps modulo 2^AW.
- LW, 16, width of the length operand; maximum transfer is 2^LW-1 words.
- DEPTH, 4, read-data FIFO depth, which is also the maximum number of outstanding requests (power of 2, >=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle command strobe; sampled only when busy=0.
- base_adr  in  AW  first word address; captured on accepted start.
- length  in  LW  number of words; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until the transfer completes.
- done  out  1  one-cycle pulse marking transfer completion.
- out_valid  out  1  stream data valid.
- out_dat  out  16  stream data, in address order.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  always 0.
- wb_adr_o  out  AW  request address.
- wb_dat_i  in  16  read data.
- wb_ack_i  in  1  one ack per accepted request, in order.
- wb_stall_i  in  1  slave stall.

Behaviour:
- Reset: busy=0, done=0, out_valid=0, wb_cyc_o=0, wb_stb_o=0, wb_adr_o=0, FIFO empty, all counters 0. Reset mid-transfer aborts at once: cyc/stb drop next edge, late acks are ignored, and done is not pulsed.
- Command acceptance:
  - start with busy=0 and length!=0 → state ISSUE next cycle; busy=1, cyc=1, stb=1, adr=base_adr.
  - start with length=0 → no bus activity; done=1 for exactly one cycle, the cycle after start; busy stays 0.
  - start while busy=1 is ignored.
- States:
  - IDLE → ISSUE on an accepted start with length!=0.
  - ISSUE → DRAIN when the last request is accepted.
  - DRAIN → IDLE when all acks are received and the FIFO is empty; done=1 on that transition cycle (registered), busy=0 the same cycle.
- Request acceptance: a request is accepted on any cycle with stb=1 and wb_stall_i=0. On acceptance, adr increments by 1 (modulo 2^AW) and the remaining-request count decrements.
- While wb_stall_i=1: stb and adr are held unchanged.
- Credit rule: stb=1 only if outstanding + fifo_count < DEPTH, where outstanding = requests accepted minus acks received. This guarantees every ack has FIFO space. When credits run out, stb deasserts (cyc stays 1) until space frees.
- cyc stays 1 from the first request until the final ack; it drops the cycle after the final ack. stb is never 1 without cyc.
- Acks:
  - wb_ack_i is honoured only while cyc=1; ack with cyc=0 is ignored.
  - wb_dat_i is written into the FIFO on the ack cycle.
  - Acceptance and ack in the same cycle update outstanding by net 0.
- FIFO:
  - Registered output: out_valid rises the cycle after the ack that fills an empty FIFO.
  - Simultaneous push and pop is allowed at any fill level, including full.
  - out_dat holds stable while out_valid=1 and out_ready=0.
- Latency, zero-wait slave, out_ready=1: start@T0 → stb@T1 (adr=base) → ack@T2 → out_valid@T3. Sustained throughput is one word per cycle.
- Counter widths: remaining and outstanding counters are sized so that length=2^LW-1 completes without overflow.

Test Plan:
- Zero-wait ROM, contents word[a]=a^16'hA5A5, base=0x0010, length=8, out_ready=1 → stb T1..T8 with adr 0x0010..0x0017; out_dat = 0xA5B5..0xA5B2 in order on T3..T10; done at T10; exactly 8 acks.
- Slave with wb_stall_i toggling 1,0,1,0 (waitcycles=1 style), length=5 → each address held while stalled; 5 words delivered in order, none duplicated or skipped.
- out_ready=0 throughout, DEPTH=4, length=10 → exactly 4 requests accepted, then stb=0 with cyc=1. Raising out_ready → remaining 6 words flow; total 10 in order.
- base=0xFFFE, length=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- length=0 → done one cycle after start; cyc never asserted. Start pulsed while busy during a length=3 transfer → ignored; exactly 3 words.
- rst asserted while 2 requests are outstanding → next cycle cyc=0, busy=0, out_valid=0; stray acks afterwards do not create out_valid; a new start then runs normally.
